// File: rtl/matmul_mac_seq.sv
// Tuple-to-address sequencer for the FP matmul engine: issues operand reads, drives the external
// MAC unit, and writes C back once the reduction index reaches num_k-1.
module matmul_mac_seq #(
   parameter int unsigned IDX_W  = 32,
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned RD_LAT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [IDX_W-1:0]  num_j_i,
   input  logic [IDX_W-1:0]  num_k_i,
   input  logic              idx_valid_i,
   output logic              idx_ready_o,
   input  logic [IDX_W-1:0]  idx_i_i,
   input  logic [IDX_W-1:0]  idx_j_i,
   input  logic [IDX_W-1:0]  idx_k_i,
   input  logic              idx_last_i,
   output logic              rd_en_o,
   output logic [ADDR_W-1:0] addr_a_o,
   output logic [ADDR_W-1:0] addr_b_o,
   output logic              mac_start_o,
   output logic              mac_clear_o,
   input  logic              mac_done_i,
   output logic              wr_en_o,
   output logic [ADDR_W-1:0] addr_c_o,
   output logic              done_o
);

   localparam int unsigned ProdW = 2 * IDX_W;
   localparam int unsigned CntW  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   typedef enum logic [2:0] {StIdle, StRd, StWait, StMac, StMwait, StWr} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]  k_q, k_d;
   logic              last_q, last_d;
   logic              done_q, done_d;
   logic [ADDR_W-1:0] addr_a_q, addr_a_d;
   logic [ADDR_W-1:0] addr_b_q, addr_b_d;
   logic [ADDR_W-1:0] addr_c_q, addr_c_d;

   logic [ProdW-1:0]  sum_a, sum_b, sum_c;
   logic              unused_sum_hi;
   logic              k_is_final;

   // Full-width products; only the low ADDR_W bits address memory.
   assign sum_a = ProdW'(idx_i_i) * ProdW'(num_k_i) + ProdW'(idx_k_i);
   assign sum_b = ProdW'(idx_k_i) * ProdW'(num_j_i) + ProdW'(idx_j_i);
   assign sum_c = ProdW'(idx_i_i) * ProdW'(num_j_i) + ProdW'(idx_j_i);
   assign unused_sum_hi = ^{sum_a[ProdW-1:ADDR_W], sum_b[ProdW-1:ADDR_W],
                            sum_c[ProdW-1:ADDR_W]};

   assign k_is_final = (k_q == (num_k_i - IDX_W'(1)));

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      k_d         = k_q;
      last_d      = last_q;
      done_d      = done_q;
      addr_a_d    = addr_a_q;
      addr_b_d    = addr_b_q;
      addr_c_d    = addr_c_q;
      idx_ready_o = 1'b0;
      rd_en_o     = 1'b0;
      mac_start_o = 1'b0;
      mac_clear_o = 1'b0;
      wr_en_o     = 1'b0;

      case (state_q)
         StIdle: begin
            idx_ready_o = 1'b1;
            if (idx_valid_i) begin
               k_d      = idx_k_i;
               last_d   = idx_last_i;
               addr_a_d = sum_a[ADDR_W-1:0];
               addr_b_d = sum_b[ADDR_W-1:0];
               addr_c_d = sum_c[ADDR_W-1:0];
               done_d   = 1'b0;
               state_d  = StRd;
            end
         end
         StRd: begin
            rd_en_o = 1'b1;
            cnt_d   = CntW'(RD_LAT - 1);
            state_d = StWait;
         end
         StWait: begin
            // Counter expires so operands land exactly RD_LAT cycles after rd_en.
            if (cnt_q == '0) begin
               state_d = StMac;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         StMac: begin
            mac_start_o = 1'b1;
            mac_clear_o = (k_q == '0);
            state_d     = StMwait;
         end
         StMwait: begin
            if (mac_done_i) begin
               state_d = k_is_final ? StWr : StIdle;
            end
         end
         StWr: begin
            wr_en_o = 1'b1;
            if (last_q) begin
               done_d = 1'b1;
            end
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q    <= '0;
         k_q      <= '0;
         last_q   <= 1'b0;
         done_q   <= 1'b0;
         addr_a_q <= '0;
         addr_b_q <= '0;
         addr_c_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         k_q      <= k_d;
         last_q   <= last_d;
         done_q   <= done_d;
         addr_a_q <= addr_a_d;
         addr_b_q <= addr_b_d;
         addr_c_q <= addr_c_d;
      end
   end

   assign addr_a_o = addr_a_q;
   assign addr_b_o = addr_b_q;
   assign addr_c_o = addr_c_q;
   assign done_o   = done_q;

endmodule

// File: tb/tb_matmul_mac_seq.sv
// Randomised bench for matmul_mac_seq: drives tuples, answers as the MAC unit, and checks
// addresses, strobes and done against a plain-arithmetic reference.
module tb_matmul_mac_seq;

   localparam int unsigned IDX_W  = 32;
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned RD_LAT = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic [IDX_W-1:0]  num_j, num_k, idx_i, idx_j, idx_k;
   logic              idx_valid, idx_ready, idx_last;
   logic              rd_en, mac_start, mac_clear, mac_done, wr_en, done;
   logic [ADDR_W-1:0] addr_a, addr_b, addr_c;

   int n_tests = 0;
   int n_fail  = 0;
   int rd_cnt  = 0;
   int wr_cnt  = 0;
   logic [ADDR_W-1:0] wr_addrs[$];
   bit done_exp = 1'b0;

   matmul_mac_seq #(.IDX_W(IDX_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
      .clk         (clk),
      .reset       (reset),
      .num_j_i     (num_j),
      .num_k_i     (num_k),
      .idx_valid_i (idx_valid),
      .idx_ready_o (idx_ready),
      .idx_i_i     (idx_i),
      .idx_j_i     (idx_j),
      .idx_k_i     (idx_k),
      .idx_last_i  (idx_last),
      .rd_en_o     (rd_en),
      .addr_a_o    (addr_a),
      .addr_b_o    (addr_b),
      .mac_start_o (mac_start),
      .mac_clear_o (mac_clear),
      .mac_done_i  (mac_done),
      .wr_en_o     (wr_en),
      .addr_c_o    (addr_c),
      .done_o      (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rd_en) rd_cnt <= rd_cnt + 1;
      if (wr_en) begin
         wr_cnt <= wr_cnt + 1;
         wr_addrs.push_back(addr_c);
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL timeout: simulation did not finish (got hang, expected finish)");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Row-major address, wrapped to the address width.
   function automatic logic [ADDR_W-1:0] ref_addr(input longint unsigned row,
                                                  input longint unsigned stride,
                                                  input longint unsigned col);
      return ADDR_W'(row * stride + col);
   endfunction

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
   task automatic run_tuple(input logic [31:0] i, input logic [31:0] j, input logic [31:0] k,
                            input bit last, input int mac_dly, input bit hold,
                            input bit spurious, input bit rst_mwait);
      logic [ADDR_W-1:0] ea, eb, ec;
      bit exp_clr, exp_wr;
      int lat, rd0, wr0, busy_bad;
      ea = ref_addr(i, num_k, k);
      eb = ref_addr(k, num_j, j);
      ec = ref_addr(i, num_j, j);
      exp_clr  = (k == 0);
      exp_wr   = (k == num_k - 32'd1);
      rd0      = rd_cnt;
      wr0      = wr_cnt;
      busy_bad = 0;
      check_eq("ready_before_accept", idx_ready, 1);
      idx_valid = 1'b1;
      idx_i = i; idx_j = j; idx_k = k; idx_last = last;
      @(negedge clk);
      if (!hold) idx_valid = 1'b0;
      done_exp = 1'b0;
      check_eq("rd_en_after_accept", rd_en, 1);
      check_eq("ready_low_in_rd", idx_ready, 0);
      check_eq("addr_a", addr_a, ea);
      check_eq("addr_b", addr_b, eb);
      check_eq("addr_c_latched", addr_c, ec);
      check_eq("done_clear_on_accept", done, 0);
      lat = 0;
      while (!mac_start && lat < 50) begin
         @(negedge clk);
         lat++;
         mac_done = spurious && (lat == 1);
         if (rd_en || idx_ready || wr_en) busy_bad++;
      end
      mac_done = 1'b0;
      check_eq("mac_start_latency", lat, RD_LAT + 1);
      check_eq("mac_clear", mac_clear, exp_clr);
      for (int c = 0; c < mac_dly; c++) begin
         @(negedge clk);
         if (idx_ready || wr_en || mac_start || rd_en) busy_bad++;
      end
      if (rst_mwait) begin
         #2 reset = 1'b1;
         #1;
         check_eq("rst_ready", idx_ready, 1);
         check_eq("rst_rd_en", rd_en, 0);
         check_eq("rst_mac_start", mac_start, 0);
         check_eq("rst_wr_en", wr_en, 0);
         check_eq("rst_done", done, 0);
         check_eq("rst_addr_c", addr_c, 0);
         @(negedge clk);
         reset = 1'b0;
         mac_done = 1'b1;
         @(negedge clk);
         mac_done = 1'b0;
         repeat (3) @(negedge clk);
         check_eq("rst_no_pending_wr", wr_cnt - wr0, 0);
         check_eq("rst_idle_after", idx_ready, 1);
         check_eq("rst_busy_ok", busy_bad, 0);
         return;
      end
      mac_done = 1'b1;
      @(negedge clk);
      mac_done = 1'b0;
      check_eq("wr_en_after_mac_done", wr_en, exp_wr);
      if (exp_wr) begin
         check_eq("addr_c_at_wr", addr_c, ec);
         check_eq("ready_low_in_wr", idx_ready, 0);
         if (last) done_exp = 1'b1;
         @(negedge clk);
      end
      check_eq("ready_back_idle", idx_ready, 1);
      check_eq("done_level", done, done_exp);
      check_eq("one_rd_per_tuple", rd_cnt - rd0, 1);
      check_eq("wr_count_tuple", wr_cnt - wr0, exp_wr);
      check_eq("busy_signals", busy_bad, 0);
   endtask

   initial begin
      int wr0, ni, nj, nk;
      logic [31:0] ri, rj, rk;
      reset = 1'b1; idx_valid = 1'b0; mac_done = 1'b0; idx_last = 1'b0;
      idx_i = '0; idx_j = '0; idx_k = '0; num_j = 32'd3; num_k = 32'd4;
      repeat (2) @(negedge clk);
      check_eq("reset_ready", idx_ready, 1);
      check_eq("reset_rd_en", rd_en, 0);
      check_eq("reset_mac_start", mac_start, 0);
      check_eq("reset_mac_clear", mac_clear, 0);
      check_eq("reset_wr_en", wr_en, 0);
      check_eq("reset_done", done, 0);
      check_eq("reset_addrs", {addr_a, addr_b, addr_c}, 0);
      reset = 1'b0;
      @(negedge clk);

      run_tuple(2, 1, 3, 0, 2, 0, 0, 0);

      num_j = 32'd3; num_k = 32'd2;
      run_tuple(0, 0, 0, 0, 1, 0, 0, 0);
      run_tuple(0, 0, 1, 0, 1, 0, 0, 0);

      run_tuple(1, 2, 0, 0, 5, 1, 0, 0);
      run_tuple(1, 2, 1, 0, 5, 1, 0, 0);
      idx_valid = 1'b0;

      run_tuple(0, 1, 0, 0, 2, 0, 1, 0);

      num_j = 32'd2; num_k = 32'd2;
      wr0 = wr_cnt;
      wr_addrs.delete();
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++)
            for (int k = 0; k < 2; k++)
               run_tuple(i, j, k, (i == 1 && j == 1 && k == 1), $urandom_range(1, 3), 0, 0, 0);
      check_eq("full_wr_count", wr_cnt - wr0, 4);
      if (wr_addrs.size() == 4)
         for (int n = 0; n < 4; n++) check_eq("full_wr_addr", wr_addrs[n], n);
      check_eq("full_done", done, 1);
      run_tuple(0, 0, 0, 0, 1, 0, 0, 0);

      run_tuple(1, 1, 1, 0, 2, 0, 0, 1);

      num_k = 32'd1; num_j = 32'd5;
      run_tuple(3, 4, 0, 1, 1, 0, 0, 0);

      for (int r = 0; r < 4; r++) begin
         ni = $urandom_range(1, 3); nj = $urandom_range(1, 4); nk = $urandom_range(1, 4);
         num_j = nj; num_k = nk;
         wr0 = wr_cnt;
         for (int i = 0; i < ni; i++)
            for (int j = 0; j < nj; j++)
               for (int k = 0; k < nk; k++)
                  run_tuple(i, j, k, (i == ni - 1 && j == nj - 1 && k == nk - 1),
                            $urandom_range(1, 4), 0, 0, 0);
         check_eq("rand_run_wr_count", wr_cnt - wr0, ni * nj);
         check_eq("rand_run_done", done, 1);
      end

      for (int r = 0; r < 20; r++) begin
         num_j = $urandom; num_k = $urandom;
         ri = $urandom; rj = $urandom;
         rk = ($urandom_range(0, 1) == 1) ? num_k - 32'd1 : $urandom;
         run_tuple(ri, rj, rk, $urandom_range(0, 1), $urandom_range(1, 3),
                   $urandom_range(0, 1), $urandom_range(0, 1), 0);
         idx_valid = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
